// File: rtl/jtcontra_gfx_pkg.sv
// Shared types and constants for the 007121-style tilemap line renderer.
package jtcontra_gfx_pkg;

    localparam int PXL_W    = 4;
    localparam int PAL_W    = 4;
    localparam int WORD_PXL = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_SCAN,
        ST_TILE,
        ST_ROMREQ,
        ST_ROMWAIT,
        ST_DUMP,
        ST_NEXT
    } state_t;

    // Pixel idx of a ROM word in screen order; flipped tiles read LSB nibble first.
    function automatic logic [PXL_W-1:0] pick_pxl(
        input logic [PXL_W*WORD_PXL-1:0] wd,
        input logic [1:0]                idx,
        input logic                      flip
    );
        logic [1:0] pos;
        pos = flip ? idx : 2'd3 - idx;
        return wd[pos*PXL_W +: PXL_W];
    endfunction

endpackage

// File: rtl/jtcontra_gfx_bank_sel.sv
// Tile attribute decode: ROM bank bits, palette and horizontal flip.
module jtcontra_gfx_bank_sel
    import jtcontra_gfx_pkg::*;
(
    input  logic [7:0]       attr_i,
    input  logic             hflip_en_i,
    input  logic             pal_msb_i,
    input  logic [3:0]       bank_mask_i,
    input  logic [3:0]       bank_bits_i,
    output logic [4:0]       bank_o,
    output logic [PAL_W-1:0] pal_o,
    output logic             flip_o
);

    always_comb begin
        bank_o[0] = attr_i[7];
        for (int i = 0; i < 4; i++)
            bank_o[i+1] = bank_mask_i[i] ? bank_bits_i[i] : attr_i[3+i];
        // attr[6] doubles as the flip bit, so it cannot also select a bank
        if (hflip_en_i)
            bank_o[4] = 1'b0;
        pal_o  = {pal_msb_i & attr_i[3], attr_i[2:0]};
        flip_o = hflip_en_i & attr_i[6];
    end

endmodule

// File: rtl/jtcontra_gfx_tmap_render.sv
// Multi-layer tilemap line renderer: tile RAM scan, SDRAM tile fetch, line buffer writes.
module jtcontra_gfx_tmap_render
    import jtcontra_gfx_pkg::*;
#(
    parameter int LAYERS  = 2,
    parameter int HEND    = 320,
    parameter int VOFFSET = 8,
    parameter int ROMW    = 18
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  LHBL,
    input  logic                  LVBL,
    input  logic [8:0]            vrender,
    input  logic [9*LAYERS-1:0]   hscroll,
    input  logic [8*LAYERS-1:0]   vscroll,
    input  logic [9*LAYERS-1:0]   dump_start,
    input  logic [LAYERS-1:0]     layer_en,
    input  logic                  hflip_en,
    input  logic                  pal_msb,
    input  logic [3:0]            bank_mask,
    input  logic [3:0]            bank_bits,
    output logic [10:0]           scan_addr,
    input  logic [7:0]            attr_scan,
    input  logic [7:0]            code_scan,
    output logic                  rom_cs,
    output logic [ROMW-1:0]       rom_addr,
    input  logic                  rom_ok,
    input  logic [15:0]           rom_data,
    output logic                  line,
    output logic [1:0]            lyr,
    output logic                  done,
    output logic [LAYERS-1:0]     line_we,
    output logic [9:0]            line_addr,
    output logic [7:0]            line_din
);

    localparam int CW = $clog2(HEND + 8) + 1;

    state_t             st_q;
    logic               lhbl_q, line_q, done_q, rom_cs_q, flip_q;
    logic [1:0]         lyr_q, dcnt_q;
    logic [LAYERS-1:0]  line_we_q;
    logic [9:0]         line_addr_q;
    logic [7:0]         line_din_q;
    logic [8:0]         vn_q, hn_q, hrender_q;
    logic [CW-1:0]      pxl_cnt_q;
    logic [12:0]        code_q;
    logic [PAL_W-1:0]   pal_q;
    logic [15:0]        data_q;

    logic [8:0]         hscr_l, dst_l, vn_d, hn_init, hr_init, hn_d;
    logic [7:0]         vscr_l;
    logic [4:0]         bank;
    logic [PAL_W-1:0]   pal;
    logic               flip, start, first_any, nxt_any;
    logic [1:0]         first_l, nxt_l;

    assign hscr_l  = hscroll[9*lyr_q +: 9];
    assign vscr_l  = vscroll[8*lyr_q +: 8];
    assign dst_l   = dump_start[9*lyr_q +: 9];
    assign vn_d    = vrender + {1'b0, vscr_l} + 9'(VOFFSET);
    assign hn_init = hscr_l & 9'h1FC;
    assign hr_init = dst_l - {7'd0, hscr_l[1:0]};
    assign hn_d    = hn_q + 9'd4;
    assign start   = LHBL & ~lhbl_q & LVBL;

    always_comb begin
        first_any = 1'b0;
        first_l   = 2'd0;
        nxt_any   = 1'b0;
        nxt_l     = 2'd0;
        for (int l = LAYERS - 1; l >= 0; l--) begin
            if (layer_en[l]) begin
                first_any = 1'b1;
                first_l   = 2'(l);
                if (l > int'(lyr_q)) begin
                    nxt_any = 1'b1;
                    nxt_l   = 2'(l);
                end
            end
        end
    end

    jtcontra_gfx_bank_sel u_bank_sel (
        .attr_i      (attr_scan),
        .hflip_en_i  (hflip_en),
        .pal_msb_i   (pal_msb),
        .bank_mask_i (bank_mask),
        .bank_bits_i (bank_bits),
        .bank_o      (bank),
        .pal_o       (pal),
        .flip_o      (flip)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q        <= ST_IDLE;
            lhbl_q      <= 1'b1;
            line_q      <= 1'b0;
            done_q      <= 1'b1;
            rom_cs_q    <= 1'b0;
            flip_q      <= 1'b0;
            lyr_q       <= 2'd0;
            dcnt_q      <= 2'd0;
            line_we_q   <= '0;
            line_addr_q <= '0;
            line_din_q  <= '0;
            vn_q        <= '0;
            hn_q        <= '0;
            hrender_q   <= '0;
            pxl_cnt_q   <= '0;
            code_q      <= '0;
            pal_q       <= '0;
            data_q      <= '0;
        end else begin
            lhbl_q <= LHBL;
            if (start) begin
                // a new line always wins, even over an outstanding ROM request
                line_q    <= ~line_q;
                rom_cs_q  <= 1'b0;
                line_we_q <= '0;
                lyr_q     <= first_l;
                done_q    <= ~first_any;
                st_q      <= first_any ? ST_INIT : ST_IDLE;
            end else begin
                case (st_q)
                    ST_INIT: begin
                        vn_q      <= vn_d;
                        hn_q      <= hn_init;
                        hrender_q <= hr_init;
                        pxl_cnt_q <= '0;
                        st_q      <= ST_SCAN;
                    end
                    ST_SCAN: st_q <= ST_TILE;
                    ST_TILE: begin
                        code_q <= {bank, code_scan};
                        pal_q  <= pal;
                        flip_q <= flip;
                        st_q   <= ST_ROMREQ;
                    end
                    ST_ROMREQ: begin
                        rom_cs_q <= 1'b1;
                        st_q     <= ST_ROMWAIT;
                    end
                    ST_ROMWAIT: if (rom_ok) begin
                        data_q   <= rom_data;
                        rom_cs_q <= 1'b0;
                        dcnt_q   <= 2'd0;
                        st_q     <= ST_DUMP;
                    end
                    ST_DUMP: begin
                        line_we_q   <= LAYERS'(1) << lyr_q;
                        line_addr_q <= {line_q, hrender_q};
                        line_din_q  <= {pal_q, pick_pxl(data_q, dcnt_q, flip_q)};
                        hrender_q   <= hrender_q + 9'd1;
                        pxl_cnt_q   <= pxl_cnt_q + CW'(1);
                        dcnt_q      <= dcnt_q + 2'd1;
                        if (dcnt_q == 2'd3)
                            st_q <= ST_NEXT;
                    end
                    ST_NEXT: begin
                        line_we_q <= '0;
                        hn_q      <= hn_d;
                        if (pxl_cnt_q < CW'(HEND + 4)) begin
                            // the second half of an 8-pixel tile reuses the latched code
                            st_q <= hn_d[2] ? ST_ROMREQ : ST_SCAN;
                        end else if (nxt_any) begin
                            lyr_q <= nxt_l;
                            st_q  <= ST_INIT;
                        end else begin
                            done_q <= 1'b1;
                            st_q   <= ST_IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign scan_addr = {lyr_q[0], vn_q[7:3], hn_q[7:3]};
    assign rom_addr  = ROMW'({code_q, vn_q[2:0], hn_q[2] ^ flip_q});
    assign rom_cs    = rom_cs_q;
    assign line      = line_q;
    assign lyr       = lyr_q;
    assign done      = done_q;
    assign line_we   = line_we_q;
    assign line_addr = line_addr_q;
    assign line_din  = line_din_q;

    logic unused_bits;
    assign unused_bits = &{1'b0, vn_q[8], hn_q[8]};

endmodule

// File: tb/tb_jtcontra_gfx_tmap_render.sv
// Directed vector bench for the tilemap line renderer.
module tb_jtcontra_gfx_tmap_render;

    localparam int LAYERS = 2, HEND = 320, VOFFSET = 8, ROMW = 18;
    localparam int NWR = HEND + 4;

    logic                clk, rst, LHBL, LVBL;
    logic [8:0]          vrender;
    logic [9*LAYERS-1:0] hscroll, dump_start;
    logic [8*LAYERS-1:0] vscroll;
    logic [LAYERS-1:0]   layer_en;
    logic                hflip_en, pal_msb;
    logic [3:0]          bank_mask, bank_bits;
    logic [10:0]         scan_addr;
    logic [7:0]          attr_scan, code_scan;
    logic                rom_cs, rom_ok;
    logic [ROMW-1:0]     rom_addr;
    logic [15:0]         rom_data;
    logic                line, done;
    logic [1:0]          lyr;
    logic [LAYERS-1:0]   line_we;
    logic [9:0]          line_addr;
    logic [7:0]          line_din;

    jtcontra_gfx_tmap_render #(.LAYERS(LAYERS), .HEND(HEND), .VOFFSET(VOFFSET), .ROMW(ROMW)) dut (
        .clk(clk), .rst(rst), .LHBL(LHBL), .LVBL(LVBL), .vrender(vrender),
        .hscroll(hscroll), .vscroll(vscroll), .dump_start(dump_start), .layer_en(layer_en),
        .hflip_en(hflip_en), .pal_msb(pal_msb), .bank_mask(bank_mask), .bank_bits(bank_bits),
        .scan_addr(scan_addr), .attr_scan(attr_scan), .code_scan(code_scan),
        .rom_cs(rom_cs), .rom_addr(rom_addr), .rom_ok(rom_ok), .rom_data(rom_data),
        .line(line), .lyr(lyr), .done(done), .line_we(line_we),
        .line_addr(line_addr), .line_din(line_din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0, bad = 0;

    // ROM responder: rom_ok after rom_lat extra cycles of rom_cs
    int rom_lat = 0, rom_wait = 0;
    bit rom_en = 1;
    initial rom_ok = 1'b0;
    always @(negedge clk) begin
        if (rom_cs && rom_en) begin
            if (rom_wait >= rom_lat) rom_ok = 1'b1;
            else begin rom_ok = 1'b0; rom_wait++; end
        end else begin
            rom_ok = 1'b0;
            rom_wait = 0;
        end
    end

    // write / request monitor
    int              wcnt[LAYERS];
    int              nwr, ra_viol, onehot_bad;
    logic [8:0]      waddr[4];
    logic [7:0]      wdin[4];
    logic [ROMW-1:0] ra_first, prev_ra;
    bit              got_ra, prev_cs;
    logic [1:0]      lyr_min;
    always @(negedge clk) begin
        if (!rst) begin
            if (line_we != '0) begin
                if ($countones(line_we) != 1) onehot_bad++;
                for (int l = 0; l < LAYERS; l++) if (line_we[l]) wcnt[l]++;
                if (nwr < 4) begin
                    waddr[nwr] = line_addr[8:0];
                    wdin[nwr]  = line_din;
                    nwr++;
                end
            end
            if (!done && lyr < lyr_min) lyr_min = lyr;
            if (rom_cs && !got_ra) begin ra_first = rom_addr; got_ra = 1; end
            if (rom_cs && prev_cs && rom_addr != prev_ra) ra_viol++;
        end
        prev_cs = rom_cs;
        prev_ra = rom_addr;
    end

    task automatic clr();
        for (int l = 0; l < LAYERS; l++) wcnt[l] = 0;
        nwr = 0; ra_viol = 0; got_ra = 0; lyr_min = 2'd3;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic start_line();
        @(posedge clk); #1 LHBL = 1'b0;
        @(posedge clk); #1 LHBL = 1'b1;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        @(posedge clk); #1;
        while (!done && n < 8000) begin @(posedge clk); #1; n++; end
        chk("done_timeout", {31'd0, done}, 32'd1);
    endtask

    task automatic wait_cs();
        int n;
        n = 0;
        while (!rom_cs && n < 100) begin @(posedge clk); #1; n++; end
        chk("cs_seen", {31'd0, rom_cs}, 32'd1);
    endtask

    typedef struct {
        logic [8:0] hs; logic [7:0] vs; logic [8:0] ds; logic [1:0] en;
        logic hf; logic pm; logic [3:0] bm; logic [3:0] bb;
        logic [7:0] attr; logic [7:0] code; logic [15:0] rd; logic [8:0] vr; int lat;
        logic [8:0] e_addr; logic [7:0] e_d0; logic [7:0] e_d1; logic [7:0] e_d2; logic [7:0] e_d3;
        logic [ROMW-1:0] e_ra; int e_w0; int e_w1; logic [1:0] e_lmin;
    } vec_t;

    vec_t vecs[6];

    task automatic apply_cfg(input vec_t v);
        hscroll = {v.hs, v.hs}; vscroll = {v.vs, v.vs}; dump_start = {v.ds, v.ds};
        layer_en = v.en; hflip_en = v.hf; pal_msb = v.pm; bank_mask = v.bm; bank_bits = v.bb;
        attr_scan = v.attr; code_scan = v.code; rom_data = v.rd; vrender = v.vr; rom_lat = v.lat;
    endtask

    logic lprev;

    initial begin
        //            hs     vs     ds      en    hf pm bm     bb     attr   code   rd        vr      lat  addr    d0..d3                      ra           w0   w1   lmin
        vecs[0] = '{9'd0, 8'h00, 9'h010, 2'b11, 0, 0, 4'h0, 4'h0, 8'h05, 8'h12, 16'h1234, 9'h020, 0, 9'h010, 8'h51, 8'h52, 8'h53, 8'h54, 18'h00120, NWR, NWR, 2'd0};
        vecs[1] = '{9'd6, 8'h00, 9'h000, 2'b11, 0, 0, 4'h0, 4'h0, 8'h05, 8'h12, 16'h1234, 9'h020, 1, 9'h1FE, 8'h51, 8'h52, 8'h53, 8'h54, 18'h00121, NWR, NWR, 2'd0};
        vecs[2] = '{9'd0, 8'h00, 9'h010, 2'b11, 1, 0, 4'h0, 4'h0, 8'h45, 8'h12, 16'h1234, 9'h020, 0, 9'h010, 8'h54, 8'h53, 8'h52, 8'h51, 18'h00121, NWR, NWR, 2'd0};
        vecs[3] = '{9'd0, 8'h00, 9'h010, 2'b10, 0, 0, 4'h0, 4'h0, 8'h05, 8'h12, 16'h1234, 9'h020, 2, 9'h010, 8'h51, 8'h52, 8'h53, 8'h54, 18'h00120, 0,   NWR, 2'd1};
        vecs[4] = '{9'd0, 8'h11, 9'h000, 2'b11, 0, 1, 4'h5, 4'h2, 8'hF8, 8'hA5, 16'hABCD, 9'h023, 0, 9'h000, 8'h8A, 8'h8B, 8'h8C, 8'h8D, 18'h15A58, NWR, NWR, 2'd0};
        vecs[5] = '{9'd3, 8'h05, 9'h001, 2'b11, 0, 0, 4'h0, 4'h0, 8'h00, 8'h00, 16'h0F0F, 9'h1F8, 0, 9'h1FE, 8'h00, 8'h0F, 8'h00, 8'h0F, 18'h0000A, NWR, NWR, 2'd0};

        onehot_bad = 0;
        rst = 1'b1; LHBL = 1'b1; LVBL = 1'b1;
        apply_cfg(vecs[0]);
        clr();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_done", {31'd0, done}, 32'd1);
        chk("rst_line", {31'd0, line}, 32'd0);
        chk("rst_cs", {31'd0, rom_cs}, 32'd0);
        chk("rst_we", {30'd0, line_we}, 32'd0);
        chk("rst_lyr", {30'd0, lyr}, 32'd0);
        chk("rst_din", {24'd0, line_din}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            apply_cfg(vecs[i]);
            clr();
            lprev = line;
            start_line();
            wait_done();
            chk($sformatf("v%0d_line", i), {31'd0, line}, {31'd0, ~lprev});
            chk($sformatf("v%0d_addr0", i), {23'd0, waddr[0]}, {23'd0, vecs[i].e_addr});
            chk($sformatf("v%0d_din0", i), {24'd0, wdin[0]}, {24'd0, vecs[i].e_d0});
            chk($sformatf("v%0d_din1", i), {24'd0, wdin[1]}, {24'd0, vecs[i].e_d1});
            chk($sformatf("v%0d_din2", i), {24'd0, wdin[2]}, {24'd0, vecs[i].e_d2});
            chk($sformatf("v%0d_din3", i), {24'd0, wdin[3]}, {24'd0, vecs[i].e_d3});
            chk($sformatf("v%0d_addr3", i), {23'd0, waddr[3]}, {23'd0, vecs[i].e_addr + 9'd3});
            chk($sformatf("v%0d_romaddr", i), 32'(ra_first), 32'(vecs[i].e_ra));
            chk($sformatf("v%0d_wr_l0", i), wcnt[0], vecs[i].e_w0);
            chk($sformatf("v%0d_wr_l1", i), wcnt[1], vecs[i].e_w1);
            chk($sformatf("v%0d_lyrmin", i), {30'd0, lyr_min}, {30'd0, vecs[i].e_lmin});
            chk($sformatf("v%0d_ra_stable", i), ra_viol, 0);
        end

        // second LHBL edge while a ROM request is outstanding
        apply_cfg(vecs[0]);
        rom_en = 0;
        clr();
        start_line();
        @(posedge clk); #1;
        wait_cs();
        lprev = line;
        LHBL = 1'b0;
        @(posedge clk); #1;
        chk("abort_cs_held", {31'd0, rom_cs}, 32'd1);
        LHBL = 1'b1;
        @(posedge clk); #1;
        chk("abort_cs_drop", {31'd0, rom_cs}, 32'd0);
        chk("abort_line", {31'd0, line}, {31'd0, ~lprev});
        chk("abort_busy", {31'd0, done}, 32'd0);
        rom_en = 1;
        clr();
        wait_done();
        chk("abort_wr_l0", wcnt[0], NWR);
        chk("abort_wr_l1", wcnt[1], NWR);
        chk("abort_addr0", {23'd0, waddr[0]}, 32'h010);
        chk("abort_din0", {24'd0, wdin[0]}, 32'h51);

        // no line starts in vertical blank
        LVBL = 1'b0;
        lprev = line;
        start_line();
        repeat (5) @(posedge clk);
        #1;
        chk("vbl_done", {31'd0, done}, 32'd1);
        chk("vbl_line", {31'd0, line}, {31'd0, lprev});
        LVBL = 1'b1;

        // all layers disabled
        layer_en = 2'b00;
        lprev = line;
        start_line();
        @(posedge clk); #1;
        chk("noen_done", {31'd0, done}, 32'd1);
        chk("noen_line", {31'd0, line}, {31'd0, ~lprev});
        repeat (10) @(posedge clk);
        #1;
        chk("noen_cs", {31'd0, rom_cs}, 32'd0);

        // asynchronous reset in the middle of a ROM request
        apply_cfg(vecs[0]);
        rom_en = 0;
        start_line();
        @(posedge clk); #1;
        wait_cs();
        #2 rst = 1'b1;
        #1;
        chk("mrst_cs", {31'd0, rom_cs}, 32'd0);
        chk("mrst_done", {31'd0, done}, 32'd1);
        chk("mrst_line", {31'd0, line}, 32'd0);
        chk("mrst_lyr", {30'd0, lyr}, 32'd0);
        chk("mrst_we", {30'd0, line_we}, 32'd0);
        chk("mrst_din", {24'd0, line_din}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        rom_en = 1;

        chk("we_onehot", onehot_bad, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
